// File: rtl/perm_pkg.sv
// ============================================================================
// Module   : perm_pkg
// Brief    : Shared constants, state encoding and arrange type for perm_search.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package perm_pkg;

    localparam int N_JOBS    = 8;
    localparam int IDX_W     = 3;
    localparam int MATCH_MAX = 15;

    typedef logic [IDX_W-1:0] arrange_t [N_JOBS];

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INIT    = 4'd1,
        ISSUE   = 4'd2,
        WAIT    = 4'd3,
        UPDATE  = 4'd4,
        FIND_I  = 4'd5,
        FIND_J  = 4'd6,
        SWAP    = 4'd7,
        REVERSE = 4'd8,
        FINISH  = 4'd9
    } state_t;

endpackage

`default_nettype wire

// File: rtl/perm_min_track.sv
// ============================================================================
// Module   : perm_min_track
// Brief    : Running minimum cost and saturating count of permutations hitting it.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module perm_min_track
    import perm_pkg::*;
#(
    parameter int COST_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              init,
    input  logic              update,
    input  logic [COST_W-1:0] cost,
    output logic [COST_W-1:0] min_cost,
    output logic [3:0]        match_count
);

    localparam logic [COST_W-1:0] c_cost_max  = '1;
    localparam logic [3:0]        c_match_max = 4'(MATCH_MAX);

    logic [COST_W-1:0] r_min;
    logic [3:0]        r_cnt;

    always_ff @(posedge CLK) begin
        if (RST || init) begin
            r_min <= c_cost_max;
            r_cnt <= '0;
        end else if (update) begin
            if (cost < r_min) begin
                r_min <= cost;
                r_cnt <= 4'd1;
            end else if ((cost == r_min) && (r_cnt != c_match_max)) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign min_cost    = r_min;
    assign match_count = r_cnt;

endmodule

`default_nettype wire

// File: rtl/perm_search.sv
// ============================================================================
// Module   : perm_search
// Brief    : Exhaustive lexicographic search over all 8! job-to-worker arranges.
//            Optional macro PERM_CNT_EN adds the perm_cnt output and counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module perm_search
    import perm_pkg::*;
#(
    parameter int COST_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              go,
    output logic              calc_start,
    output logic [IDX_W-1:0]  arrange [N_JOBS],
    input  logic              calc_done,
    input  logic [COST_W-1:0] calc_cost,
    output logic [COST_W-1:0] MinCost,
    output logic [3:0]        MatchCount,
`ifdef PERM_CNT_EN
    output logic [15:0]       perm_cnt,
`endif
    output logic              done
);

    localparam logic [IDX_W-1:0] c_one   = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_last  = IDX_W'(N_JOBS - 1);
    localparam logic [IDX_W-1:0] c_scan0 = IDX_W'(N_JOBS - 2);

    state_t            r_state;
    state_t            w_next;
    arrange_t          r_arrange;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_i;
    logic [IDX_W-1:0]  r_l;
    logic [IDX_W-1:0]  r_r;
    logic [COST_W-1:0] r_cost;
    logic              r_done;
    logic              w_lt_i;
    logic              w_gt_j;
    logic              w_init;
    logic              w_update;

    // r_idx walks i in FIND_I and then j in FIND_J, so it still holds j in SWAP
    assign w_lt_i = r_arrange[r_idx] < r_arrange[r_idx + c_one];
    assign w_gt_j = r_arrange[r_idx] > r_arrange[r_i];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        calc_start = 1'b0;
        w_init     = 1'b0;
        w_update   = 1'b0;
        case (r_state)
            IDLE:    if (go) w_next = INIT;
            INIT: begin
                w_init = 1'b1;
                w_next = ISSUE;
            end
            ISSUE: begin
                calc_start = 1'b1;
                w_next     = WAIT;
            end
            WAIT:    if (calc_done) w_next = UPDATE;
            UPDATE: begin
                w_update = 1'b1;
                w_next   = FIND_I;
            end
            FIND_I: begin
                if (w_lt_i)            w_next = FIND_J;
                else if (r_idx == '0)  w_next = FINISH;
            end
            FIND_J:  if (w_gt_j) w_next = SWAP;
            SWAP:    w_next = REVERSE;
            REVERSE: if (!(r_l < r_r)) w_next = ISSUE;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < N_JOBS; k++) r_arrange[k] <= IDX_W'(k);
            r_idx  <= '0;
            r_i    <= '0;
            r_l    <= '0;
            r_r    <= '0;
            r_cost <= '0;
            r_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    for (int k = 0; k < N_JOBS; k++) r_arrange[k] <= IDX_W'(k);
                    r_done <= 1'b0;
                end
                WAIT:   if (calc_done) r_cost <= calc_cost;
                UPDATE: r_idx <= c_scan0;
                FIND_I: begin
                    if (w_lt_i) begin
                        r_i   <= r_idx;
                        r_idx <= c_last;
                    end else if (r_idx != '0) begin
                        r_idx <= r_idx - c_one;
                    end
                end
                FIND_J: if (!w_gt_j) r_idx <= r_idx - c_one;
                SWAP: begin
                    r_arrange[r_i]   <= r_arrange[r_idx];
                    r_arrange[r_idx] <= r_arrange[r_i];
                    r_l              <= r_i + c_one;
                    r_r              <= c_last;
                end
                REVERSE: begin
                    if (r_l < r_r) begin
                        r_arrange[r_l] <= r_arrange[r_r];
                        r_arrange[r_r] <= r_arrange[r_l];
                        r_l            <= r_l + c_one;
                        r_r            <= r_r - c_one;
                    end
                end
                FINISH: r_done <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef PERM_CNT_EN
    logic [15:0] r_perm_cnt;

    always_ff @(posedge CLK) begin
        if (RST || w_init) begin
            r_perm_cnt <= '0;
        end else if (w_update) begin
            r_perm_cnt <= r_perm_cnt + 16'd1;
        end
    end

    assign perm_cnt = r_perm_cnt;
`endif

    perm_min_track #(
        .COST_W (COST_W)
    ) u_min_track (
        .CLK         (CLK),
        .RST         (RST),
        .init        (w_init),
        .update      (w_update),
        .cost        (r_cost),
        .min_cost    (MinCost),
        .match_count (MatchCount)
    );

    assign arrange = r_arrange;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_perm_search.sv
// ============================================================================
// Module   : tb_perm_search
// Brief    : Self-checking bench for perm_search with a calculator stub.
//            Honours PERM_CNT_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_perm_search;
    import perm_pkg::*;

    localparam int              COST_W   = 10;
    localparam int              NPERM    = 40320;
    localparam int              NT       = 8;
    localparam int              NR       = 300;
    localparam logic [23:0]     ID_ARR   = 24'o01234567;
    localparam logic [COST_W-1:0] COST_MAX = '1;

    logic              CLK = 1'b0;
    logic              RST;
    logic              go;
    logic              calc_start;
    logic [IDX_W-1:0]  arrange [N_JOBS];
    logic              calc_done;
    logic [COST_W-1:0] calc_cost;
    logic [COST_W-1:0] MinCost;
    logic [3:0]        MatchCount;
    logic              done;
`ifdef PERM_CNT_EN
    logic [15:0]       perm_cnt;
`endif

    always #5 CLK = ~CLK;

    perm_search #(.COST_W(COST_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .go         (go),
        .calc_start (calc_start),
        .arrange    (arrange),
        .calc_done  (calc_done),
        .calc_cost  (calc_cost),
        .MinCost    (MinCost),
        .MatchCount (MatchCount),
`ifdef PERM_CNT_EN
        .perm_cnt   (perm_cnt),
`endif
        .done       (done)
    );

    typedef struct {
        int          cost;
        logic [23:0] arr;
        int          exp_min;
        int          exp_cnt;
    } vec_t;

    vec_t        tbl [NT];
    int          errors = 0;
    int          checks = 0;
    int          mode = 0;       // 0 distance, 1 constant 5, 2 random, 3 table
    int          lat_fixed = 3;
    bit          lat_rand = 1'b0;
    bit          spur_en = 1'b0;
    logic [23:0] issued [$];
    int          mins [$];
    int          cnts [$];
    int          costs_sent [$];
    int          stab_err = 0;

    function automatic bit chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (octal %0o), expected %0d (octal %0o)", name, act, act, exp, exp);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [23:0] cur_arr();
        logic [23:0] p = '0;
        for (int k = 0; k < N_JOBS; k++) p = {p[20:0], arrange[k]};
        return p;
    endfunction

    // k-th permutation in lexicographic order via the factorial number system
    function automatic logic [23:0] perm_of_rank(input int rank);
        int          avail [$];
        int          r, f, idx;
        logic [23:0] p = '0;
        for (int k = 0; k < N_JOBS; k++) avail.push_back(k);
        r = rank;
        for (int pos = 0; pos < N_JOBS; pos++) begin
            f = 1;
            for (int m = 2; m <= N_JOBS - 1 - pos; m++) f *= m;
            idx = r / f;
            r   = r % f;
            p   = {p[20:0], 3'(avail[idx])};
            avail.delete(idx);
        end
        return p;
    endfunction

    function automatic int cost_of(input int idx, input logic [23:0] p);
        int s = 0;
        int d;
        case (mode)
            0: begin
                for (int k = 0; k < N_JOBS; k++) begin
                    d = int'(p[23-3*k -: 3]) - k;
                    s += (d < 0) ? -d : d;
                end
            end
            1: s = 5;
            2: s = int'($urandom_range(10, 50));
            default: s = (idx < NT) ? tbl[idx].cost : 500;
        endcase
        return s;
    endfunction

    // Calculator stub: acts just after each falling edge, away from the active edge
    initial begin : stub
        bit pend = 1'b0;
        int cnt = 0;
        int pcost = 0;
        int spur_cnt = 0;
        calc_done = 1'b0;
        calc_cost = '0;
        forever begin
            @(negedge CLK);
            #1;
            calc_done = 1'b0;
            if (RST) begin
                pend     = 1'b0;
                spur_cnt = 0;
            end else begin
                if (spur_cnt > 0) begin
                    spur_cnt--;
                    if (spur_cnt == 0) begin
                        calc_done = 1'b1;
                        calc_cost = '0;
                    end
                end
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        if (cur_arr() !== issued[$]) stab_err++;
                        calc_done = 1'b1;
                        calc_cost = COST_W'(pcost);
                        costs_sent.push_back(pcost);
                        pend = 1'b0;
                        if (spur_en) spur_cnt = 2;
                    end
                end
                if (calc_start) begin
                    issued.push_back(cur_arr());
                    mins.push_back(int'(MinCost));
                    cnts.push_back(int'(MatchCount));
                    pcost = cost_of(issued.size() - 1, cur_arr());
                    pend  = 1'b1;
                    cnt   = lat_rand ? int'($urandom_range(1, 4)) : lat_fixed;
                end
            end
        end
    end

    initial begin : watchdog
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        issued.delete();
        mins.delete();
        cnts.delete();
        costs_sent.delete();
        stab_err = 0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge CLK);
        go = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_issues(input int n, input int budget);
        int c = 0;
        while ((issued.size() < n) && (c < budget)) begin
            @(negedge CLK);
            c++;
        end
        if (issued.size() < n) void'(chk("timeout_issue", issued.size(), n));
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while ((done !== 1'b1) && (c < budget)) begin
            @(negedge CLK);
            c++;
        end
        if (done !== 1'b1) void'(chk("timeout_done", done, 1));
    endtask

    task automatic check_idle_state(input string tag);
        void'(chk({tag, "_calc_start"}, calc_start, 0));
        void'(chk({tag, "_done"}, done, 0));
        void'(chk({tag, "_mincost"}, MinCost, 1023));
        void'(chk({tag, "_matchcount"}, MatchCount, 0));
        void'(chk({tag, "_arrange"}, cur_arr(), ID_ARR));
`ifdef PERM_CNT_EN
        void'(chk({tag, "_perm_cnt"}, perm_cnt, 0));
`endif
    endtask

    initial begin : main
        int nerr;
        int mm, cc;
        tbl[0] = '{1023, 24'o01234567, 1023, 1};
        tbl[1] = '{1023, 24'o01234576, 1023, 2};
        tbl[2] = '{9,    24'o01234657, 9,    1};
        tbl[3] = '{9,    24'o01234675, 9,    2};
        tbl[4] = '{12,   24'o01234756, 9,    2};
        tbl[5] = '{3,    24'o01234765, 3,    1};
        tbl[6] = '{0,    24'o01235467, 0,    1};
        tbl[7] = '{0,    24'o01235476, 0,    2};

        // Reset with go held: reset wins and nothing starts afterwards
        RST = 1'b1;
        go  = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        go  = 1'b0;
        check_idle_state("reset");
        repeat (5) @(negedge CLK);
        void'(chk("go_with_rst_ignored", issued.size(), 0));

        // Ordering and min/count update rules from a cost table, latency 3
        mode = 3;
        lat_fixed = 3;
        clear_log();
        pulse_go();
        wait_issues(NT + 1, 2000);
        if (issued.size() >= NT + 1) begin
            void'(chk("tbl_init_min", mins[0], 1023));
            void'(chk("tbl_init_cnt", cnts[0], 0));
            for (int k = 0; k < NT; k++) begin
                void'(chk($sformatf("tbl_arr_%0d", k), issued[k], tbl[k].arr));
                void'(chk($sformatf("tbl_min_%0d", k), mins[k+1], tbl[k].exp_min));
                void'(chk($sformatf("tbl_cnt_%0d", k), cnts[k+1], tbl[k].exp_cnt));
            end
        end

        // Reset while WAITing for the calculator
        wait_issues(issued.size() + 1, 200);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_idle_state("midrst");
        clear_log();
        repeat (6) @(negedge CLK);
        void'(chk("midrst_stays_idle", issued.size(), 0));
        pulse_go();
        wait_issues(2, 200);
        if (issued.size() >= 2) begin
            void'(chk("restart_first", issued[0], ID_ARR));
            void'(chk("restart_second", issued[1], 24'o01234576));
        end

        // Random costs and latencies, go held high, spurious calc_done in FIND_I
        do_reset();
        clear_log();
        mode     = 2;
        lat_rand = 1'b1;
        spur_en  = 1'b1;
        go       = 1'b1;
        wait_issues(NR + 1, 20000);
        go = 1'b0;
        if (issued.size() >= NR + 1) begin
            nerr = 0;
            for (int k = 0; k <= NR; k++) if (issued[k] !== perm_of_rank(k)) nerr++;
            void'(chk("rand_order_errors", nerr, 0));
            mm = 1023;
            cc = 0;
            for (int k = 1; k <= NR; k++) begin
                if (costs_sent[k-1] < mm) begin
                    mm = costs_sent[k-1];
                    cc = 1;
                end else if ((costs_sent[k-1] == mm) && (cc < 15)) begin
                    cc++;
                end
                if (!chk($sformatf("rand_min_%0d", k), mins[k], mm)) break;
                if (!chk($sformatf("rand_cnt_%0d", k), cnts[k], cc)) break;
            end
        end
        void'(chk("rand_arrange_stable", stab_err, 0));

        // Full search, unique minimum at identity
        do_reset();
        clear_log();
        mode     = 0;
        lat_rand = 1'b0;
        spur_en  = 1'b0;
        lat_fixed = 1;
        pulse_go();
        wait_issues(1, 100);
        wait_done(600000);
        void'(chk("uniq_done", done, 1));
        void'(chk("uniq_mincost", MinCost, 0));
        void'(chk("uniq_matchcount", MatchCount, 1));
`ifdef PERM_CNT_EN
        void'(chk("uniq_perm_cnt", perm_cnt, NPERM));
`endif
        void'(chk("uniq_issue_count", issued.size(), NPERM));
        nerr = 0;
        for (int k = 0; k < issued.size() && k < NPERM; k++) if (issued[k] !== perm_of_rank(k)) nerr++;
        void'(chk("uniq_order_errors", nerr, 0));
        void'(chk("uniq_arrange_stable", stab_err, 0));
        repeat (5) @(negedge CLK);
        void'(chk("done_sticky", done, 1));
        void'(chk("no_issue_after_done", issued.size(), NPERM));

        // Full search, constant cost saturates the match counter
        mode = 1;
        clear_log();
        pulse_go();
        wait_issues(1, 100);
        void'(chk("done_cleared_by_init", done, 0));
        wait_done(600000);
        void'(chk("sat_mincost", MinCost, 5));
        void'(chk("sat_matchcount", MatchCount, 15));
        void'(chk("sat_calc_start_pulses", issued.size(), NPERM));
`ifdef PERM_CNT_EN
        void'(chk("sat_perm_cnt", perm_cnt, NPERM));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/perm_search.md
PERM_SEARCH -- requirements
Module: perm_search

Interface
REQ-001 SHALL have parameter COST_W, default 10, giving the width of the cost input and of MinCost.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port go, input, 1 bit: single-cycle request to start an exhaustive search; sampled only in IDLE.
REQ-005 SHALL have port calc_start, output, 1 bit: single-cycle pulse asking the cost calculator to evaluate the current arrange.
REQ-006 SHALL have port arrange, output, unpacked array of 8 x 3 bits: current job permutation, where arrange[w] is the job given to worker w.
REQ-007 SHALL have port calc_done, input, 1 bit: the calculator has finished, and calc_cost is valid in the same cycle.
REQ-008 SHALL have port calc_cost, input, COST_W bits: total cost of the current arrange.
REQ-009 SHALL have port MinCost, output, COST_W bits: global minimum cost found.
REQ-010 SHALL have port MatchCount, output, 4 bits: number of permutations that achieve MinCost.
REQ-011 SHALL have port done, output, 1 bit: the search is complete and the results are valid.

Function
REQ-012 SHALL use FSM states IDLE, INIT, ISSUE, WAIT, UPDATE, FIND_I, FIND_J, SWAP, REVERSE, FINISH.
REQ-013 SHALL go IDLE->INIT on go=1 and SHALL hold in IDLE otherwise.
REQ-014 SHALL, in INIT, load arrange[k]=k, MinCost=2^COST_W-1, MatchCount=0, done=0, then go to ISSUE.
REQ-015 SHALL, in ISSUE, drive calc_start=1 for exactly one cycle and hold arrange stable until UPDATE has completed.
REQ-016 SHALL hold in WAIT until calc_done=1, capturing calc_cost in that cycle, then go to UPDATE.
REQ-017 SHALL, in UPDATE: if cost<MinCost, set MinCost=cost and MatchCount=1; else if cost==MinCost, increment MatchCount, saturating at 15; otherwise leave both unchanged.
REQ-018 SHALL step arrange to the next lexicographic permutation, examining one index per cycle.
REQ-019 SHALL, in FIND_I, scan i from 6 down to 0 for the first arrange[i]<arrange[i+1].
REQ-020 SHALL, in FIND_J, scan j from 7 down for the first arrange[j]>arrange[i].
REQ-021 SHALL, in SWAP, exchange arrange[i] and arrange[j].
REQ-022 SHALL, in REVERSE, swap one pair per cycle with l starting at i+1 and r at 7, while l<r, then go to ISSUE.
REQ-023 SHALL go FIND_I->FINISH if no valid i exists at index 0, i.e. arrange=7,6,5,4,3,2,1,0, after 7 FIND_I cycles.
REQ-024 SHALL, in FINISH, set done=1 and return to IDLE; done stays 1 until the next INIT.
REQ-025 SHALL evaluate exactly 40320 permutations per search, each exactly once.
REQ-026 SHALL ignore go outside IDLE and SHALL ignore calc_done outside WAIT.
REQ-027 SHALL, when go and RST are asserted together, give RST priority.

Reset
REQ-028 SHALL, on RST=1 at a clock edge, set state=IDLE, calc_start=0, done=0, MinCost=2^COST_W-1, MatchCount=0, arrange[k]=k, and perm_cnt=0 if present.
REQ-029 SHALL, on RST mid-search in any state, abandon the search; the next go restarts the search from identity.

Configuration
REQ-030 SHALL, with PERM_CNT_EN defined, add output perm_cnt[15:0], cleared in INIT and incremented in each UPDATE; it reads 40320 at done.
REQ-031 SHALL, without PERM_CNT_EN, have neither the perm_cnt port nor its counter, and all other behaviour SHALL be identical.

Structure
REQ-032 SHALL put the state enum, N_JOBS=8, IDX_W=3, MATCH_MAX=15 and the arrange array typedef in shared package perm_pkg.
REQ-033 SHALL place the UPDATE compare/saturate logic in sub-module perm_min_track; the permutation-stepping FSM stays in perm_search.

Verification
REQ-034 SHALL verify reset: RST high for 2 cycles -> calc_start=0, done=0, MinCost=1023, MatchCount=0, arrange=0,1,2,3,4,5,6,7.
REQ-035 SHALL verify ordering: go with a calculator stub answering calc_done 3 cycles after calc_start -> first three issued arrange values are 01234567, 01234576, 01234657.
REQ-036 SHALL verify a unique minimum: stub cost = sum over k of |arrange[k]-k| -> done=1 with MinCost=0, MatchCount=1, perm_cnt=40320 with PERM_CNT_EN.
REQ-037 SHALL verify saturation: stub returns constant 5 -> MinCost=5, MatchCount=15, exactly 40320 calc_start pulses.
REQ-038 SHALL verify mid-search reset: RST asserted in WAIT -> next cycle IDLE, calc_start=0, done=0; a later go restarts from 01234567.
REQ-039 SHALL verify ignored events: go pulsed during REVERSE and calc_done pulsed during FIND_I -> no restart, no extra UPDATE, and the permutation sequence is unchanged.
